// File: rtl/bit_width_expander_pkg.sv
// rtl/bit_width_expander_pkg.sv - shared sizing and lane helpers for the width reducer/expander pair
package bit_width_expander_pkg;

  // Fill value for lanes that carry no data
  localparam logic PAD_BIT = 1'b1;

  // Number of bits needed to represent value (never less than one)
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  // Bit offset of a lane inside a packed wide word
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/bit_width_expander_lane_acc.sv
// rtl/bit_width_expander_lane_acc.sv - narrow-lane accumulator that assembles one wide word
module bit_width_expander_lane_acc
  import bit_width_expander_pkg::*;
#(
  parameter int DIN_WIDTH = 64,
  parameter int RATIO     = 2,
  parameter int CNT_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       last,
  input  logic [DIN_WIDTH-1:0]       din,
  output logic                       close,
  output logic [DIN_WIDTH*RATIO-1:0] word,
  output logic [CNT_WIDTH-1:0]       lane_cnt
);

  localparam int DOUT_WIDTH = DIN_WIDTH * RATIO;
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  logic [DOUT_WIDTH-1:0] acc;

  // A word closes when the top lane is filled or the producer marks the end early
  always_comb begin
    close = load & (last | (lane_cnt == LAST_LANE));
  end

  // Completed word: held lanes plus the incoming word; higher lanes are still padding
  always_comb begin
    word = acc;
    word[lane_base(int'(lane_cnt), DIN_WIDTH) +: DIN_WIDTH] = din;
  end

  // Lane storage and fill pointer; restart from padding after every close
  always_ff @(posedge clk) begin
    if (clear) begin
      acc      <= {DOUT_WIDTH{PAD_BIT}};
      lane_cnt <= '0;
    end else if (close) begin
      acc      <= {DOUT_WIDTH{PAD_BIT}};
      lane_cnt <= '0;
    end else if (load) begin
      acc[lane_base(int'(lane_cnt), DIN_WIDTH) +: DIN_WIDTH] <= din;
      lane_cnt <= lane_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bit_width_expander.sv
// rtl/bit_width_expander.sv - packs narrow stream words into wide FIFO writes
module bit_width_expander
  import bit_width_expander_pkg::*;
#(
  parameter int DIN_WIDTH  = 64,
  parameter int DOUT_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DIN_WIDTH-1:0]  DIN,
  input  logic                  DIN_VALID,
  input  logic                  DIN_LAST,
  output logic                  DIN_READY,
  output logic [DOUT_WIDTH-1:0] FIFO_DIN,
  output logic                  FIFO_WE,
  input  logic                  FIFO_FULL,
  input  logic                  FIFO_RST_BUSY,
  output logic                  BUSY,
  output logic [31:0]           WORD_COUNT
);

  localparam int RATIO          = DOUT_WIDTH / DIN_WIDTH;
  localparam int LANE_CNT_WIDTH = clogb2(RATIO - 1);
  localparam int CNT_WIDTH      = LANE_CNT_WIDTH + 1;

  logic                  can_write;
  logic                  accept;
  logic                  close;
  logic [DOUT_WIDTH-1:0] word;
  logic [CNT_WIDTH-1:0]  lane_cnt;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] out_data;
  logic [31:0]           word_cnt;

  // Handshake: a reset-busy FIFO is treated the same as a full one
  always_comb begin
    can_write = ~FIFO_FULL & ~FIFO_RST_BUSY;
    FIFO_WE   = out_valid & can_write;
    DIN_READY = ~RESET & (~out_valid | FIFO_WE);
    accept    = DIN_VALID & DIN_READY;
    FIFO_DIN  = out_data;
    BUSY      = out_valid | (lane_cnt != '0);
  end

  assign WORD_COUNT = word_cnt;

  bit_width_expander_lane_acc #(
    .DIN_WIDTH (DIN_WIDTH),
    .RATIO     (RATIO),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_lane_acc (
    .clk      (CLK),
    .clear    (RESET),
    .load     (accept),
    .last     (DIN_LAST),
    .din      (DIN),
    .close    (close),
    .word     (word),
    .lane_cnt (lane_cnt)
  );

  // One-entry output stage: a new word may replace the one being written this cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_data  <= {DOUT_WIDTH{PAD_BIT}};
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= word;
    end else if (FIFO_WE) begin
      out_valid <= 1'b0;
    end
  end

  // Count of wide words handed to the FIFO, wrapping naturally
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_cnt <= '0;
    end else if (FIFO_WE) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

endmodule

// File: doc/bit_width_expander.md
Name: bit_width_expander

Overview:
Inverse of the FIFO-side width reducer. Accepts a stream of narrow DIN_WIDTH words under a valid/ready handshake and packs RATIO = DOUT_WIDTH/DIN_WIDTH consecutive words into one wide word. It writes each wide word into an external write-side FIFO, honouring full and reset-busy backpressure. Lane order and padding match the reducer: first word in lane 0 (LSBs), unused lanes are all-ones.

Parameters:
DIN_WIDTH, 64, narrow input word width
DOUT_WIDTH, 128, wide packed word width; must be an integer multiple of DIN_WIDTH with RATIO >= 2
(derived constant) RATIO = DOUT_WIDTH/DIN_WIDTH; LANE_CNT_WIDTH = clogb2(RATIO-1)

Ports:
CLK  in  1  single clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
DIN  in  DIN_WIDTH  narrow input word
DIN_VALID  in  1  DIN is valid this cycle
DIN_LAST  in  1  with DIN_VALID: close the current wide word after this lane, padding the rest
DIN_READY  out  1  block can accept DIN this cycle
FIFO_DIN  out  DOUT_WIDTH  packed wide word to the FIFO
FIFO_WE  out  1  FIFO write enable
FIFO_FULL  in  1  FIFO full
FIFO_RST_BUSY  in  1  FIFO in reset, no writes permitted
BUSY  out  1  partial word held or wide word pending
WORD_COUNT  out  32  number of wide words written since reset; wraps modulo 2^32

Behaviour:
- Registered state: acc (DOUT_WIDTH), lane_cnt (LANE_CNT_WIDTH+1 bits, range 0..RATIO-1), out_valid, out_data (DOUT_WIDTH), word_cnt.
- can_write = ~FIFO_FULL & ~FIFO_RST_BUSY.
- FIFO_WE = out_valid & can_write (combinational). FIFO_DIN = out_data.
- DIN_READY = ~RESET & (~out_valid | FIFO_WE). This is a one-entry output stage. A full input stream with no backpressure sustains one narrow word per cycle.
- accept = DIN_VALID & DIN_READY. When DIN_VALID=0, DIN_LAST is ignored.
- On accept with lane_cnt < RATIO-1 and DIN_LAST=0:
  - acc lane[lane_cnt] <= DIN
  - lane_cnt <= lane_cnt+1
- On accept with lane_cnt == RATIO-1, or with DIN_LAST=1 (close event):
  - out_data <= acc with lane[lane_cnt] replaced by DIN; lanes above lane_cnt are already all-ones
  - out_valid <= 1; acc <= all-ones; lane_cnt <= 0
- If FIFO_WE and no close event in the same cycle: out_valid <= 0.
- Simultaneous FIFO_WE and close event: out_valid stays 1 and out_data takes the new word. The old word was written this cycle, so nothing is lost.
- word_cnt increments on every FIFO_WE cycle.
- Latency: the closing narrow word is accepted in cycle N; FIFO_WE is high in cycle N+1 if can_write. Otherwise FIFO_WE is held, with FIFO_DIN stable, until can_write.
- Backpressure: while out_valid & ~can_write, DIN_READY=0. Partial acc lanes are retained and never overwritten.
- FIFO_RST_BUSY is treated exactly as full. No write occurs during it, and the pending word survives it.
- DIN_LAST at lane 0: emits a word with lane 0 = DIN and every other lane all-ones.
- BUSY = out_valid | (lane_cnt != 0).
- Reset (synchronous, any cycle, including mid-word or with a word pending):
  - acc = all-ones, out_data = all-ones, lane_cnt = 0, out_valid = 0, word_cnt = 0
  - Outputs: FIFO_WE=0, DIN_READY=0, BUSY=0, FIFO_DIN=all-ones, WORD_COUNT=0
  - Partial and pending data are discarded.
- No X propagation: FIFO_DIN is always a defined register value.

Decomposition:
- Shared package: the clogb2 function, the all-ones pad constant, and the lane-index helper, all shared with the width reducer.
- One natural sub-module: bit_width_expander_lane_acc. It holds acc and lane_cnt, inputs load/close/clear, and outputs the completed word plus a close strobe.
- The top level owns the output stage, handshake and counter.

Test Plan:
1. Reset, then stream 4 words with no backpressure: 64'h1, 64'h2, 64'h3, 64'h4. Required: FIFO_WE pulses one cycle after words 2 and 4, with FIFO_DIN = 128'h2_0000000000000001 then 128'h4_0000000000000003. Then WORD_COUNT=2 and BUSY=0.
2. Send 64'hA with DIN_LAST=1 at lane 0. Required: FIFO_DIN = {64'hFFFF_FFFF_FFFF_FFFF, 64'hA}, WORD_COUNT increments by 1.
3. Hold FIFO_FULL=1 and send 64'h5, 64'h6, 64'h7. Required:
   - FIFO_WE stays 0 and DIN_READY drops after 64'h6.
   - 64'h7 is held with acc unchanged.
   - On releasing FULL: write 128'h6_…_5 first, then 64'h7 is accepted in the same cycle.
4. Continuous 6-word stream with FIFO_WE coinciding with the next close. Required: 3 writes on consecutive even cycles, DIN_READY never deasserts, no word lost or duplicated.
5. Assert FIFO_RST_BUSY for 5 cycles with a word pending. Required: no write during the busy window, then exactly one write of the held word.
6. Pulse RESET after 1 lane accepted and with a word pending. Required: next cycle FIFO_WE=0, BUSY=0, WORD_COUNT=0, and the next two words form a fresh wide word with no stale lane.
